// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the read-sequencer state encoding.
// Used by the frame buffer read side, the HDMI path and the write-side controller.
package vga_timing_pkg;

  localparam int VGA_H_ACT  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOT  = VGA_H_ACT + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACT  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOT  = VGA_V_ACT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Stored camera image; displayed with 2x nearest-neighbour upscaling.
  localparam int VGA_IMG_W  = 320;
  localparam int VGA_IMG_H  = 240;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One counter width serves both the pixel and the line counter.
  function automatic int cnt_width(input int h_tot, input int v_tot);
    return $clog2((h_tot > v_tot) ? h_tot : v_tot);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with active and sync decode.
// Ports:
//   pclk, rst_n  pixel clock, async active-low reset
//   i_run        count enable; while low both counters are held at 0
//   h_cnt/v_cnt  raster position
//   active       position is inside the visible area
//   hs/vs        sync pulse window (active high here; polarity is set by the user)
//   frame_end    last pixel of the last line
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT  = VGA_H_ACT,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_ACT  = VGA_V_ACT,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter int CNT_W  = cnt_width(H_ACT + H_FP + H_SYNC + H_BP, V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             i_run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs,
  output logic             frame_end
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_last;
  logic             w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign h_cnt     = r_h_cnt;
  assign v_cnt     = r_v_cnt;
  // Gated by i_run so the held (0,0) position in idle does not decode as video.
  assign active    = i_run && (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign hs        = i_run && (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign vs        = i_run && (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign frame_end = i_run && w_h_last && w_v_last;

endmodule

// File: rtl/frame_buffer_reader.sv
// Read-side sequencer for the dual-port frame buffer. Produces VGA raster timing,
// reads the stored image with 2x nearest-neighbour upscaling and aligns pixel data
// with sync/de across the buffer's 1-cycle read latency.
// Ports:
//   pclk, rst_n   pixel clock, async active-low reset
//   en            run request, honoured only on frame boundaries
//   rAddr, OE     frame buffer read address / read enable
//   rData         RGB565 from the buffer, valid the cycle after OE
//   hsync, vsync  active-low syncs
//   de, pix       active-video qualifier and RGB565 pixel (0 outside de)
//   frame_start   pulse with the first active pixel of each frame
//
// state   | meaning
// IDLE    | counters held at 0, outputs at reset values, wait for en
// RUN     | raster running; en re-checked on the last pixel of each frame
module frame_buffer_reader
  import vga_timing_pkg::*;
#(
  parameter int IMG_W  = VGA_IMG_W,
  parameter int IMG_H  = VGA_IMG_H,
  parameter int H_ACT  = VGA_H_ACT,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_ACT  = VGA_V_ACT,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rAddr,
  output logic              OE,
  input  logic [15:0]       rData,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [15:0]       pix,
  output logic              frame_start
);

  localparam int CNT_W = cnt_width(H_ACT + H_FP + H_SYNC + H_BP, V_ACT + V_FP + V_SYNC + V_BP);

  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(IMG_W);
  localparam logic [CNT_W-1:0]  H_ACT_LAST = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0]  V_ACT_LAST = CNT_W'(V_ACT - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_run;

  logic [CNT_W-1:0]   w_h_cnt;
  logic [CNT_W-1:0]   w_v_cnt;
  logic               w_active;
  logic               w_hs;
  logic               w_vs;
  logic               w_frame_end;
  logic               w_first_pix;
  logic               w_line_done;

  logic [ADDR_W-1:0]  r_line_base;
  logic               r_hs_s1;
  logic               r_vs_s1;
  logic               r_fs_s1;
  logic               r_de_s2;
  logic               r_hs_s2;
  logic               r_vs_s2;
  logic               r_fs_s2;

  // ---------------- FSM ----------------
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en)                 w_state_nxt = ST_RUN;
      ST_RUN:  if (w_frame_end && !en) w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    if (r_state == ST_RUN) w_run = 1'b1;
  end

  // ---------------- stage 0: raster counters ----------------
  vga_timing_gen #(
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .CNT_W  (CNT_W)
  ) u_timing (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .h_cnt     (w_h_cnt),
    .v_cnt     (w_v_cnt),
    .active    (w_active),
    .hs        (w_hs),
    .vs        (w_vs),
    .frame_end (w_frame_end)
  );

  assign w_first_pix = w_active && (w_h_cnt == '0) && (w_v_cnt == '0);
  // Each stored line is shown twice, so the base only advances after odd lines.
  // The final odd line is skipped so the base never points past the image.
  assign w_line_done = w_active && (w_h_cnt == H_ACT_LAST) && w_v_cnt[0] &&
                       (w_v_cnt != V_ACT_LAST);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_base <= '0;
    end else if (!w_run || w_frame_end) begin
      r_line_base <= '0;
    end else if (w_line_done) begin
      r_line_base <= r_line_base + LINE_STEP;
    end
  end

  // ---------------- stage 1: buffer request ----------------
  // OE doubles as the stage-1 de flag.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rAddr   <= '0;
      OE      <= 1'b0;
      r_hs_s1 <= 1'b0;
      r_vs_s1 <= 1'b0;
      r_fs_s1 <= 1'b0;
    end else begin
      OE      <= w_active;
      r_hs_s1 <= w_hs;
      r_vs_s1 <= w_vs;
      r_fs_s1 <= w_first_pix;
      if (!w_run) begin
        rAddr <= '0;
      end else if (w_active) begin
        rAddr <= r_line_base + ADDR_W'(w_h_cnt >> 1);
      end
    end
  end

  // ---------------- stage 2: buffer read in flight ----------------
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_s2 <= 1'b0;
      r_hs_s2 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_fs_s2 <= 1'b0;
    end else begin
      r_de_s2 <= OE;
      r_hs_s2 <= r_hs_s1;
      r_vs_s2 <= r_vs_s1;
      r_fs_s2 <= r_fs_s1;
    end
  end

  // ---------------- stage 3: aligned video outputs ----------------
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      pix         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      de          <= r_de_s2;
      pix         <= r_de_s2 ? rData : '0;
      hsync       <= ~r_hs_s2;
      vsync       <= ~r_vs_s2;
      frame_start <= r_fs_s2;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench: a small-raster instance (full logic, short frames) and a
// default 640x480 instance (first few lines only) checked against a frame-position
// reference model.
module tb_frame_buffer_reader;

  // index 0: reduced raster, index 1: default 640x480 timing
  localparam int C_IMG_W  [2] = '{10, 320};
  localparam int C_H_ACT  [2] = '{20, 640};
  localparam int C_H_FP   [2] = '{3, 16};
  localparam int C_H_SYNC [2] = '{4, 96};
  localparam int C_H_TOT  [2] = '{32, 800};
  localparam int C_V_ACT  [2] = '{12, 480};
  localparam int C_V_FP   [2] = '{2, 10};
  localparam int C_V_SYNC [2] = '{2, 2};
  localparam int C_V_TOT  [2] = '{19, 525};
  localparam int S_FRM = 32 * 19;
  localparam int S_LAST_ADDR = 10 * 6 - 1;

  typedef struct {
    int          due;
    logic        de;
    logic [15:0] pix;
    logic        hs;
    logic        vs;
    logic        fs;
    int          addr;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        en;

  logic [5:0]  raddr_s;
  logic        oe_s;
  logic [15:0] rdata_s;
  logic        hsync_s, vsync_s, de_s, fs_s;
  logic [15:0] pix_s;

  logic [16:0] raddr_f;
  logic        oe_f;
  logic [15:0] rdata_f;
  logic        hsync_f, vsync_f, de_f, fs_f;
  logic [15:0] pix_f;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bit   m_run [2];
  int   m_pos [2];
  exp_t q_s[$];
  exp_t q_f[$];
  exp_t q_a[$];
  exp_t e_s, e_f, e_a;

  always #5 pclk = ~pclk;

  frame_buffer_reader #(
    .IMG_W(10), .IMG_H(6),
    .H_ACT(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACT(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_s (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .rAddr(raddr_s), .OE(oe_s), .rData(rdata_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .pix(pix_s),
    .frame_start(fs_s)
  );

  frame_buffer_reader u_dut_f (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .rAddr(raddr_f), .OE(oe_f), .rData(rdata_f),
    .hsync(hsync_f), .vsync(vsync_f), .de(de_f), .pix(pix_f),
    .frame_start(fs_f)
  );

  // Frame buffers: one-cycle read returning the address as data.
  always @(posedge pclk) if (oe_s) rdata_s <= {10'd0, raddr_s};
  always @(posedge pclk) if (oe_f) rdata_f <= raddr_f[15:0];

  function automatic exp_t model_out(int k, bit run, int pos, int due);
    exp_t e;
    int   x, y;
    x      = pos % C_H_TOT[k];
    y      = pos / C_H_TOT[k];
    e.due  = due;
    e.de   = run && (x < C_H_ACT[k]) && (y < C_V_ACT[k]);
    e.addr = (y / 2) * C_IMG_W[k] + x / 2;
    e.pix  = e.de ? 16'(e.addr) : 16'h0;
    e.hs   = !(run && (x >= C_H_ACT[k] + C_H_FP[k]) && (x < C_H_ACT[k] + C_H_FP[k] + C_H_SYNC[k]));
    e.vs   = !(run && (y >= C_V_ACT[k] + C_V_FP[k]) && (y < C_V_ACT[k] + C_V_FP[k] + C_V_SYNC[k]));
    e.fs   = run && (pos == 0);
    return e;
  endfunction

  // Reference model: position within the frame, or not running.
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 1'b0;
        m_pos[k] = 0;
      end
      q_s.delete();
      q_f.delete();
      q_a.delete();
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!m_run[k]) begin
          if (en) begin
            m_run[k] = 1'b1;
            m_pos[k] = 0;
          end
        end else if (m_pos[k] == C_H_TOT[k] * C_V_TOT[k] - 1) begin
          if (en) m_pos[k] = 0;
          else    m_run[k] = 1'b0;
        end else begin
          m_pos[k]++;
        end
      end
      q_s.push_back(model_out(0, m_run[0], m_pos[0], cyc + 3));
      q_f.push_back(model_out(1, m_run[1], m_pos[1], cyc + 3));
      q_a.push_back(model_out(0, m_run[0], m_pos[0], cyc + 1));
    end
  end

  task automatic chk_out(string tag, exp_t e, logic d, logic [15:0] p, logic h, logic v, logic f);
    n_cmp++;
    if ({d, p, h, v, f} !== {e.de, e.pix, e.hs, e.vs, e.fs}) begin
      n_err++;
      $display("FAIL %s cyc=%0d got de=%b pix=%0d hs=%b vs=%b fs=%b exp de=%b pix=%0d hs=%b vs=%b fs=%b",
               tag, cyc, d, p, h, v, f, e.de, e.pix, e.hs, e.vs, e.fs);
    end
  endtask

  // Monitor: pops expectations as their output cycle comes up.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (q_s.size() > 0 && q_s[0].due == cyc) begin
        e_s = q_s.pop_front();
        chk_out("video_small", e_s, de_s, pix_s, hsync_s, vsync_s, fs_s);
      end
      if (q_f.size() > 0 && q_f[0].due == cyc) begin
        e_f = q_f.pop_front();
        chk_out("video_full", e_f, de_f, pix_f, hsync_f, vsync_f, fs_f);
      end
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        e_a = q_a.pop_front();
        n_cmp++;
        if (oe_s !== e_a.de || (e_a.de && raddr_s !== 6'(e_a.addr))) begin
          n_err++;
          $display("FAIL read_req cyc=%0d got oe=%b addr=%0d exp oe=%b addr=%0d",
                   cyc, oe_s, raddr_s, e_a.de, e_a.addr);
        end
      end
      n_cmp++;
      if (oe_s && raddr_s > 6'(S_LAST_ADDR)) begin
        n_err++;
        $display("FAIL addr_bound cyc=%0d got addr=%0d max=%0d", cyc, raddr_s, S_LAST_ADDR);
      end
    end
  end

  task automatic chk_reset(string tag);
    n_cmp++;
    if ({raddr_s, oe_s, hsync_s, vsync_s, de_s, pix_s, fs_s} !== {6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL %s_small got addr=%0d oe=%b hs=%b vs=%b de=%b pix=%0d fs=%b exp addr=0 oe=0 hs=1 vs=1 de=0 pix=0 fs=0",
               tag, raddr_s, oe_s, hsync_s, vsync_s, de_s, pix_s, fs_s);
    end
    n_cmp++;
    if ({raddr_f, oe_f, hsync_f, vsync_f, de_f, pix_f, fs_f} !== {17'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL %s_full got addr=%0d oe=%b hs=%b vs=%b de=%b pix=%0d fs=%b exp addr=0 oe=0 hs=1 vs=1 de=0 pix=0 fs=0",
               tag, raddr_f, oe_f, hsync_f, vsync_f, de_f, pix_f, fs_f);
    end
  endtask

  task automatic wait_pos(string tag, int target);
    int n;
    n = 0;
    while (!(m_run[0] && m_pos[0] == target) && n < 2 * S_FRM) begin
      @(negedge pclk);
      n++;
    end
    n_cmp++;
    if (n >= 2 * S_FRM) begin
      n_err++;
      $display("FAIL %s timeout got pos=%0d exp pos=%0d", tag, m_pos[0], target);
    end
  endtask

  initial begin
    int tgt;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge pclk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (10) @(negedge pclk);

    // Random en: only the level at frame end (or in idle) may matter.
    for (int i = 0; i < 1500; i++) begin
      @(negedge pclk);
      en = ($urandom_range(0, 3) != 0);
    end

    en = 1'b1;
    repeat (2 * S_FRM + 50) @(negedge pclk);

    // Mid-frame en drop: the frame must complete, then stay idle.
    tgt = $urandom_range(2, 10) * 32 + $urandom_range(0, 31);
    wait_pos("en_drop", tgt);
    en = 1'b0;
    repeat (S_FRM + 40) @(negedge pclk);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      n_cmp++;
      if ({oe_s, de_s, hsync_s, vsync_s} !== 4'b0011) begin
        n_err++;
        $display("FAIL idle_hold cyc=%0d got oe=%b de=%b hs=%b vs=%b exp oe=0 de=0 hs=1 vs=1",
                 cyc, oe_s, de_s, hsync_s, vsync_s);
      end
    end

    // Mid-frame asynchronous reset inside the active area, restart with en held.
    en = 1'b1;
    tgt = $urandom_range(1, 10) * 32 + $urandom_range(0, 19);
    wait_pos("reset_pos", tgt);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (S_FRM + 20) @(negedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
